data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Responder end of the CPU data-SRAM interface. Accepts the core's `data_sram_en`/`we`/`addr`/`wdata` requests and returns `data_sram_rdata` one cycle later. Decodes each request to either a word-addressed on-chip RAM or a small configuration-register window: LED, switch, number display, simulation flag and a free-running timer. Sits outside `mycpu_top` in the SoC shell, directly on the core's data port.

## Interface
Parameters:
- `ADDR_W`, 10: RAM word-address width (RAM depth = 2^ADDR_W words).
- `CONF_BASE`, 16'hbfaf: `addr[31:16]` value selecting the config window.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `data_sram_en`  in  1  — request valid this cycle.
- `data_sram_we`  in  4  — byte write enables; 0 = read, non-zero = write.
- `data_sram_addr`  in  32  — byte address; `addr[1:0]` ignored.
- `data_sram_wdata`  in  32  — write data, lane i = bits [8i+7:8i].
- `data_sram_rdata`  out  32  — registered read data.
- `switch_in`  in  8  — board switches, read-only through config window.
- `led`  out  16  — LED register.
- `num_data`  out  32  — number-display register.

## Operation
- Decode: `addr[31:16]==CONF_BASE` → config window, offset = `addr[15:0]`; otherwise RAM. RAM index = `addr[ADDR_W+1:2]`; higher bits alias.
- Config map (word offsets):
  - 16'he000 TIMER: read/write.
  - 16'hf020 LED: bits [15:0] read/write; upper bits read 0.
  - 16'hf030 SWITCH: read-only, zero-extended `switch_in`.
  - 16'hf050 NUM: read/write.
  - 16'hffec SIMU_FLAG: reads 32'hffffffff.
  - Any other offset reads 0. Writes to SWITCH, SIMU_FLAG or unmapped offsets are ignored.
- Write (`en && we!=0`): only lanes with a set `we` bit are updated; other lanes keep their value.
- Write cycle leaves `data_sram_rdata` unchanged (holds its previous value).
- Read (`en && we==0`): selected data is captured into `data_sram_rdata` at the edge.
- `en==0`: no state change; `data_sram_rdata` holds.
- TIMER:
  - 32-bit, increments by 1 every cycle; wraps 32'hffffffff → 0.
  - A write in cycle N loads the byte-merged value of (current timer, wdata) at edge N instead of incrementing.
  - Increments resume from the next cycle.
- RAM is not reset; reading a never-written RAM word returns an undefined value and benches must not check it.
- Reset values: `data_sram_rdata`=0, `led`=0, `num_data`=0, timer=0.
- Reset is asynchronous and may assert mid-request; the request is dropped.
- RAM contents survive reset.

## Timing
- Read latency: exactly 1 cycle. A request at cycle N gives valid `rdata` from edge N until the next read's edge.
- A write at cycle N is visible to a read issued at cycle N+1; that read's `rdata` is valid after edge N+1.
- Back-to-back reads every cycle are supported; there is no stall or backpressure.
- TIMER read at cycle N returns the timer value present during cycle N, i.e. before that edge's increment.
- `led` and `num_data` change at the edge of the writing cycle.
- No combinational path from any input to any output.

## Configuration
- `DATA_RESP_TIMER_EN` defined: TIMER register implemented as described above.
- `DATA_RESP_TIMER_EN` undefined:
  - No timer counter is built.
  - Offset 16'he000 reads 0 and writes to it are ignored, like an unmapped offset.
  - All other behaviour is unchanged.

## Test plan
- Reset, then read NUM and LED: `rdata`=0, `led`=0, `num_data`=0.
- Write 32'h12345678 to RAM 0x1c000100 with we=4'hf; then write 32'hAABBCCDD to the same address with we=4'b0101; read it back → 32'h12BB56DD, one cycle after the read request.
- Write 32'h0000_BEEF to 0xbfaff020 → `led`=16'hbeef from the next cycle; read it back → 32'h0000beef. Read 0xbfaff030 with `switch_in`=8'h5a → 32'h0000005a. Read 0xbfafffec → 32'hffffffff.
- Write 32'hffff_fffe to TIMER at cycle N; read TIMER at N+1 → 32'hfffffffe; read at N+3 → 32'h00000000 (wrap).
  - With the macro undefined, the same reads return 0.
- Read-hold: read RAM word A (value 32'h11), then a write cycle, then two idle cycles → `rdata` stays 32'h11 throughout.
- Assert `reset` asynchronously mid-stream while `led` holds a non-zero value → `led`, `num_data` and `rdata` go 0 immediately without a clock edge; a RAM word written before reset still reads back its value.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word RAM plus config window (LED/SWITCH/NUM/SIMU_FLAG, TIMER only with DATA_RESP_TIMER_EN).
// Read data is registered with 1-cycle latency and held between reads; it never stalls and applies no backpressure.
module data_sram_responder #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led,
    output logic [31:0] num_data
);
    localparam logic [15:0] OFF_TIMER  = 16'he000;
    localparam logic [15:0] OFF_LED    = 16'hf020;
    localparam logic [15:0] OFF_SWITCH = 16'hf030;
    localparam logic [15:0] OFF_NUM    = 16'hf050;
    localparam logic [15:0] OFF_SIMU   = 16'hffec;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [31:0]       ram_q [0:(1<<ADDR_W)-1];
    logic [31:0]       rdata_q, rdata_d;
    logic [15:0]       led_q, led_d;
    logic [31:0]       num_q, num_d;
    logic [31:0]       timer_rd;
    logic [31:0]       conf_rd;
    logic              is_conf, rd_req, wr_req, ram_we;
    logic [15:0]       off;
    logic [ADDR_W-1:0] ram_idx;
    logic              unused_addr_lsb;

    // Byte offset bits never take part in decode; the map is word-granular.
    assign unused_addr_lsb = ^data_sram_addr[1:0];
    assign is_conf = (data_sram_addr[31:16] == CONF_BASE);
    assign off     = {data_sram_addr[15:2], 2'b00};
    assign ram_idx = data_sram_addr[ADDR_W+1:2];
    assign rd_req  = data_sram_en && (data_sram_we == 4'h0);
    assign wr_req  = data_sram_en && (data_sram_we != 4'h0);
    assign ram_we  = wr_req && !is_conf && !reset;

`ifdef DATA_RESP_TIMER_EN
    logic [31:0] timer_q, timer_d;

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (wr_req && is_conf && (off == OFF_TIMER))
            timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_we);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end

    assign timer_rd = timer_q;
`else
    assign timer_rd = '0;
`endif

    always_comb begin
        conf_rd = '0;
        case (off)
            OFF_TIMER:  conf_rd = timer_rd;
            OFF_LED:    conf_rd = {16'h0, led_q};
            OFF_SWITCH: conf_rd = {24'h0, switch_in};
            OFF_NUM:    conf_rd = num_q;
            OFF_SIMU:   conf_rd = 32'hffff_ffff;
            default:    conf_rd = '0;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        led_d   = led_q;
        num_d   = num_q;
        if (rd_req)
            rdata_d = is_conf ? conf_rd : ram_q[ram_idx];
        if (wr_req && is_conf && (off == OFF_LED)) begin
            if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
            if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
        end
        if (wr_req && is_conf && (off == OFF_NUM))
            num_d = byte_merge(num_q, data_sram_wdata, data_sram_we);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
            led_q   <= '0;
            num_q   <= '0;
        end else begin
            rdata_q <= rdata_d;
            led_q   <= led_d;
            num_q   <= num_d;
        end
    end

    // RAM has no reset so its contents survive; writes are suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) ram_q[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign led             = led_q;
    assign num_data        = num_q;
endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed vector table, multi-cycle sequences, randomized model check.
module tb_data_sram_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr, wdata, rdata, num;
    logic [7:0]  sw;
    logic [15:0] led;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    data_sram_responder dut (
        .clk             (clk),
        .reset           (rst),
        .data_sram_en    (en),
        .data_sram_we    (we),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch_in       (sw),
        .led             (led),
        .num_data        (num)
    );

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        logic [31:0] rd;
        logic [15:0] led;
        logic [31:0] num;
        string       nm;
    } vec_t;

    vec_t tbl [22];

    // Behavioural model state for the randomized phase.
    logic [31:0] m_ram [8];
    logic [31:0] m_rd, m_num;
    logic [15:0] m_led;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one request for one cycle; returns 1 time unit after the edge.
    task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] d, input logic [7:0] s);
        en = e; we = w; addr = a; wdata = d; sw = s;
        @(posedge clk);
        #1;
        en = 1'b0; we = 4'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ram_addr(input int idx);
        logic [15:0] up;
        logic [3:0]  mid;
        logic [1:0]  lo;
        logic [2:0]  ix;
        up  = 16'($urandom_range(0, 16'hbfae));
        mid = 4'($urandom);
        lo  = 2'($urandom);
        ix  = 3'(idx);
        return {up, mid, 7'b0, ix, lo};
    endfunction

    initial begin
        logic [31:0] exp_t1, exp_t3;
        rst = 1'b1; en = 1'b0; we = 4'h0; addr = '0; wdata = '0; sw = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_num", num, 32'h0);
        rst = 1'b0;

        tbl[0]  = '{1'b1, 4'h0, 32'hbfaff050, 32'h0,        8'h00, 32'h0,        16'h0,    32'h0,        "rd_num_after_reset"};
        tbl[1]  = '{1'b1, 4'h0, 32'hbfaff020, 32'h0,        8'h00, 32'h0,        16'h0,    32'h0,        "rd_led_after_reset"};
        tbl[2]  = '{1'b1, 4'hf, 32'h1c000100, 32'h12345678, 8'h00, 32'h0,        16'h0,    32'h0,        "ram_wr_full"};
        tbl[3]  = '{1'b1, 4'h5, 32'h1c000100, 32'haabbccdd, 8'h00, 32'h0,        16'h0,    32'h0,        "ram_wr_lanes"};
        tbl[4]  = '{1'b1, 4'h0, 32'h1c000100, 32'h0,        8'h00, 32'h12bb56dd, 16'h0,    32'h0,        "ram_rd_merged"};
        tbl[5]  = '{1'b1, 4'hf, 32'hbfaff020, 32'h0000beef, 8'h00, 32'h12bb56dd, 16'hbeef, 32'h0,        "led_wr"};
        tbl[6]  = '{1'b1, 4'h0, 32'hbfaff020, 32'h0,        8'h00, 32'h0000beef, 16'hbeef, 32'h0,        "led_rd"};
        tbl[7]  = '{1'b1, 4'h0, 32'hbfaff030, 32'h0,        8'h5a, 32'h0000005a, 16'hbeef, 32'h0,        "switch_rd"};
        tbl[8]  = '{1'b1, 4'h0, 32'hbfafffec, 32'h0,        8'h00, 32'hffffffff, 16'hbeef, 32'h0,        "simu_rd"};
        tbl[9]  = '{1'b1, 4'hf, 32'hbfafffec, 32'h0,        8'h00, 32'hffffffff, 16'hbeef, 32'h0,        "simu_wr_ignored"};
        tbl[10] = '{1'b1, 4'h0, 32'hbfafffec, 32'h0,        8'h00, 32'hffffffff, 16'hbeef, 32'h0,        "simu_rd_again"};
        tbl[11] = '{1'b1, 4'hf, 32'hbfaff050, 32'hcafef00d, 8'h00, 32'hffffffff, 16'hbeef, 32'hcafef00d, "num_wr"};
        tbl[12] = '{1'b1, 4'h8, 32'hbfaff050, 32'h11223344, 8'h00, 32'hffffffff, 16'hbeef, 32'h11fef00d, "num_wr_lane3"};
        tbl[13] = '{1'b1, 4'h0, 32'hbfaff050, 32'h0,        8'h00, 32'h11fef00d, 16'hbeef, 32'h11fef00d, "num_rd"};
        tbl[14] = '{1'b1, 4'hf, 32'hbfaff030, 32'h0,        8'h3c, 32'h11fef00d, 16'hbeef, 32'h11fef00d, "switch_wr_ignored"};
        tbl[15] = '{1'b1, 4'h0, 32'hbfaff030, 32'h0,        8'h3c, 32'h0000003c, 16'hbeef, 32'h11fef00d, "switch_rd2"};
        tbl[16] = '{1'b1, 4'hf, 32'hbfaf1234, 32'hdeadbeef, 8'h00, 32'h0000003c, 16'hbeef, 32'h11fef00d, "unmapped_wr"};
        tbl[17] = '{1'b1, 4'h0, 32'hbfaf1234, 32'h0,        8'h00, 32'h0,        16'hbeef, 32'h11fef00d, "unmapped_rd"};
        tbl[18] = '{1'b1, 4'hc, 32'hbfaff020, 32'hffff0000, 8'h00, 32'h0,        16'hbeef, 32'h11fef00d, "led_wr_upper_lanes"};
        tbl[19] = '{1'b1, 4'h1, 32'hbfaff020, 32'h00000012, 8'h00, 32'h0,        16'hbe12, 32'h11fef00d, "led_wr_lane0"};
        tbl[20] = '{1'b0, 4'hf, 32'hbfaff020, 32'h00000000, 8'h00, 32'h0,        16'hbe12, 32'h11fef00d, "idle_no_effect"};
        tbl[21] = '{1'b1, 4'h0, 32'hbfaff023, 32'h0,        8'h00, 32'h0000be12, 16'hbe12, 32'h11fef00d, "led_rd_byte_off"};

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sw);
            chk({tbl[i].nm, "_rdata"}, rdata, tbl[i].rd);
            chk({tbl[i].nm, "_led"}, {16'h0, led}, {16'h0, tbl[i].led});
            chk({tbl[i].nm, "_num"}, num, tbl[i].num);
        end

        // Timer: load, read next cycle, then observe the wrap two cycles later.
`ifdef DATA_RESP_TIMER_EN
        exp_t1 = 32'hfffffffe; exp_t3 = 32'h0;
`else
        exp_t1 = 32'h0;        exp_t3 = 32'h0;
`endif
        drive(1'b1, 4'hf, 32'hbfafe000, 32'hfffffffe, 8'h0);
        drive(1'b1, 4'h0, 32'hbfafe000, 32'h0, 8'h0);
        chk("timer_rd_after_load", rdata, exp_t1);
        drive(1'b0, 4'h0, 32'h0, 32'h0, 8'h0);
        drive(1'b1, 4'h0, 32'hbfafe000, 32'h0, 8'h0);
        chk("timer_rd_wrap", rdata, exp_t3);

        // Read-hold across a write and two idle cycles.
        drive(1'b1, 4'hf, 32'h1c000200, 32'h11, 8'h0);
        drive(1'b1, 4'h0, 32'h1c000200, 32'h0, 8'h0);
        chk("hold_rd", rdata, 32'h11);
        drive(1'b1, 4'hf, 32'h1c000204, 32'h99, 8'h0);
        chk("hold_after_wr", rdata, 32'h11);
        drive(1'b0, 4'h0, 32'h1c000200, 32'h0, 8'h0);
        chk("hold_idle1", rdata, 32'h11);
        drive(1'b0, 4'h0, 32'h1c000200, 32'h0, 8'h0);
        chk("hold_idle2", rdata, 32'h11);

        // Asynchronous reset mid-cycle, with a write request pending across the reset edge.
        drive(1'b1, 4'hf, 32'hbfaff020, 32'h000000a5, 8'h0);
        drive(1'b1, 4'hf, 32'hbfaff050, 32'h00000005, 8'h0);
        chk("pre_reset_led", {16'h0, led}, 32'h00a5);
        en = 1'b1; we = 4'hf; addr = 32'h1c000200; wdata = 32'hdeadbeef;
        #2 rst = 1'b1;
        #1;
        chk("async_reset_led", {16'h0, led}, 32'h0);
        chk("async_reset_num", num, 32'h0);
        chk("async_reset_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        en = 1'b0; we = 4'h0;
        rst = 1'b0;
        drive(1'b1, 4'h0, 32'h1c000200, 32'h0, 8'h0);
        chk("ram_survives_reset", rdata, 32'h11);

        // Randomized phase against the behavioural model.
        rst = 1'b1;
        #2 rst = 1'b0;
        m_rd = 32'h0; m_led = 16'h0; m_num = 32'h0;
        for (int i = 0; i < 8; i++) begin
            m_ram[i] = $urandom;
            drive(1'b1, 4'hf, ram_addr(i), m_ram[i], 8'($urandom));
        end
        for (int c = 0; c < 400; c++) begin
            int          op, idx;
            logic [3:0]  w;
            logic [31:0] a, d;
            logic [7:0]  s;
            logic [15:0] offs [6];
            offs[0] = 16'hf020; offs[1] = 16'hf030; offs[2] = 16'hf050;
            offs[3] = 16'hffec; offs[4] = 16'h1234; offs[5] = 16'h0004;
            op  = $urandom_range(0, 9);
            idx = $urandom_range(0, 7);
            d   = $urandom;
            s   = 8'($urandom);
            w   = 4'($urandom_range(1, 15));
            if (op >= 6) a = {16'hbfaf, offs[$urandom_range(0, 5)] | 16'($urandom_range(0, 3))};
            else         a = ram_addr(idx);
            case (op)
                0: drive(1'b0, w, a, d, s);
                1, 2, 3: begin
                    m_rd = m_ram[idx];
                    drive(1'b1, 4'h0, a, d, s);
                end
                4, 5: begin
                    m_ram[idx] = merge(m_ram[idx], d, w);
                    drive(1'b1, w, a, d, s);
                end
                6, 7: begin
                    case ({a[15:2], 2'b00})
                        16'hf020: m_rd = {16'h0, m_led};
                        16'hf030: m_rd = {24'h0, s};
                        16'hf050: m_rd = m_num;
                        16'hffec: m_rd = 32'hffffffff;
                        default:  m_rd = 32'h0;
                    endcase
                    drive(1'b1, 4'h0, a, d, s);
                end
                default: begin
                    if ({a[15:2], 2'b00} == 16'hf020) m_led = merge({16'h0, m_led}, d, w & 4'h3);
                    if ({a[15:2], 2'b00} == 16'hf050) m_num = merge(m_num, d, w);
                    drive(1'b1, w, a, d, s);
                end
            endcase
            chk("rand_rdata", rdata, m_rd);
            chk("rand_led", {16'h0, led}, {16'h0, m_led});
            chk("rand_num", num, m_num);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
